// File: rtl/multiplicador_sequencial_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding, default operand width and a two's-complement negate helper.
package multiplicador_sequencial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Widest value the negate helper handles; products up to 64 bits.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negation at MAX_W bits; callers zero-extend the
    // operand in and truncate the result back to their own width, which
    // is exact modulo 2^width.
    function automatic logic [MAX_W-1:0] twos_negate(input logic [MAX_W-1:0] v);
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/multiplicador_sequencial_somador_n_bits.sv
// Ripple-carry adder built from chained one-bit full adders; used for the
// per-iteration partial-product add of the multiplier.

// One-bit full adder.
module Somador1Bit (
    output logic o_sum,
    output logic o_cout,
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// WIDTH-bit ripple-carry adder with carry-in and carry-out.
module somador_n_bits #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;
    assign o_cout     = w_carry[WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        Somador1Bit u_fa (
            .o_sum  (o_sum[g]),
            .o_cout (w_carry[g+1]),
            .i_a    (i_a[g]),
            .i_b    (i_b[g]),
            .i_cin  (w_carry[g])
        );
    end
endmodule

// File: rtl/multiplicador_sequencial.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation. Signed operands are reduced to magnitudes at
// accept time, multiplied unsigned over WIDTH iterations, and the sign is
// applied when the product is registered.
module multiplicador_sequencial
    import multiplicador_sequencial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mult;
    logic [WIDTH-1:0]     r_acc_hi;
    logic                 r_neg;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_acc_hi_next;
    logic [WIDTH-1:0]     w_mult_next;
    logic [2*WIDTH-1:0]   w_prod;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits W bits.
    always_comb begin
        w_a_mag = A;
        w_b_mag = B;
        if (signed_mode && A[WIDTH-1])
            w_a_mag = WIDTH'(twos_negate(MAX_W'(A)));
        if (signed_mode && B[WIDTH-1])
            w_b_mag = WIDTH'(twos_negate(MAX_W'(B)));
    end

    assign w_addend = r_mult[0] ? r_mcand : '0;

    somador_n_bits #(
        .WIDTH (WIDTH)
    ) u_somador (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // {carry, sum, multiplier} shifted right by one; the multiplier register
    // doubles as the low half of the accumulator.
    assign w_acc_hi_next = {w_cout, w_sum[WIDTH-1:1]};
    assign w_mult_next   = {w_sum[0], r_mult[WIDTH-1:1]};
    assign w_prod        = {w_acc_hi_next, w_mult_next};

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mult      <= '0;
            r_acc_hi    <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_p         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mcand    <= w_a_mag;
                        r_mult     <= w_b_mag;
                        r_neg      <= signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_acc_hi   <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_acc_hi_next;
                    r_mult   <= w_mult_next;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_p         <= r_neg ? (2*WIDTH)'(twos_negate(MAX_W'(w_prod))) : w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign P         = r_p;

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Testbench for multiplicador_sequencial: directed WIDTH=4 vectors and
// corner sequences, plus a WIDTH=8 random sweep against an arithmetic model.
module tb_multiplicador_sequencial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       in_valid4 = 0, out_ready4 = 0, sm4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       in_ready4, out_valid4, busy4;
    logic [7:0] p4;

    // WIDTH=8 instance
    logic       in_valid8 = 0, out_ready8 = 0, sm8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       in_ready8, out_valid8, busy8;
    logic [15:0] p8;

    multiplicador_sequencial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .signed_mode(sm4), .out_valid(out_valid4),
        .out_ready(out_ready4), .P(p4), .busy(busy4)
    );

    multiplicador_sequencial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .signed_mode(sm8), .out_valid(out_valid8),
        .out_ready(out_ready8), .P(p8), .busy(busy8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] p;
    } vec_t;

    // One full operation on the WIDTH=4 instance. Pulses in_valid and
    // scrambles operands while busy, holds out_ready low for 'hold' cycles.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input int hold, input logic [7:0] exp, input string tag);
        int lat;
        chk({tag, " in_ready before accept"}, 32'(in_ready4), 32'd1);
        a4 = a; b4 = b; sm4 = sm; in_valid4 = 1;
        step();
        in_valid4 = 0;
        a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
        chk({tag, " in_ready after accept"}, 32'(in_ready4), 32'd0);
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            in_valid4 = 1'($urandom);
            step();
            lat++;
        end
        in_valid4 = 0;
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " P"}, 32'(p4), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid4 = 1;
            step();
            chk({tag, " hold P"}, 32'(p4), 32'(exp));
            chk({tag, " hold out_valid"}, 32'(out_valid4), 32'd1);
            chk({tag, " hold in_ready"}, 32'(in_ready4), 32'd0);
        end
        in_valid4 = 0;
        out_ready4 = 1;
        step();
        out_ready4 = 0;
        chk({tag, " out_valid after handshake"}, 32'(out_valid4), 32'd0);
        chk({tag, " in_ready after handshake"}, 32'(in_ready4), 32'd1);
        chk({tag, " P retained in IDLE"}, 32'(p4), 32'(exp));
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] exp8;
        int sa, sb, lat, seen;

        vecs.push_back('{4'hF, 4'hF, 1'b0, 8'hE1});
        vecs.push_back('{4'h8, 4'h8, 1'b1, 8'h40});
        vecs.push_back('{4'hD, 4'h5, 1'b1, 8'hF1});
        vecs.push_back('{4'h7, 4'hF, 1'b1, 8'hF9});
        vecs.push_back('{4'h0, 4'h9, 1'b0, 8'h00});
        vecs.push_back('{4'h1, 4'hB, 1'b0, 8'h0B});
        vecs.push_back('{4'h1, 4'hB, 1'b1, 8'hFB});
        vecs.push_back('{4'h8, 4'h8, 1'b0, 8'h40});
        vecs.push_back('{4'h8, 4'h7, 1'b1, 8'hC8});
        vecs.push_back('{4'hF, 4'hF, 1'b1, 8'h01});

        // Reset state
        step();
        step();
        chk("rst in_ready4", 32'(in_ready4), 32'd1);
        chk("rst out_valid4", 32'(out_valid4), 32'd0);
        chk("rst busy4", 32'(busy4), 32'd0);
        chk("rst P4", 32'(p4), 32'd0);
        chk("rst in_ready8", 32'(in_ready8), 32'd1);
        chk("rst P8", 32'(p8), 32'd0);
        rst_n = 1;
        step();

        // Directed vectors; the first one exercises 3 cycles of backpressure
        for (int i = 0; i < vecs.size(); i++)
            run4(vecs[i].a, vecs[i].b, vecs[i].sm, (i == 0) ? 3 : int'($urandom_range(0, 1)),
                 vecs[i].p, $sformatf("vec%0d", i));

        // Reset two cycles into CALC
        a4 = 4'd5; b4 = 4'd5; sm4 = 0; in_valid4 = 1;
        step();
        in_valid4 = 0;
        step();
        step();
        chk("midrst busy before", 32'(busy4), 32'd1);
        rst_n = 0;
        #1;
        chk("midrst in_ready", 32'(in_ready4), 32'd1);
        chk("midrst out_valid", 32'(out_valid4), 32'd0);
        chk("midrst busy", 32'(busy4), 32'd0);
        chk("midrst P", 32'(p4), 32'd0);
        step();
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid4) seen = 1;
        end
        chk("midrst no out_valid", 32'(seen), 32'd0);
        run4(4'd6, 4'd7, 1'b0, 0, 8'h2A, "after_rst");

        // WIDTH=8 random sweep
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            sa = sm8 ? int'($signed(a8)) : int'(a8);
            sb = sm8 ? int'($signed(b8)) : int'(b8);
            exp8 = 16'(sa * sb);
            lat = 0;
            while (!in_ready8 && lat < 20) begin
                step();
                lat++;
            end
            in_valid8 = 1;
            step();
            in_valid8 = 0;
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            lat = 0;
            while (!out_valid8 && lat < 20) begin
                step();
                lat++;
            end
            chk($sformatf("w8 op%0d latency", n), 32'(lat), 32'd8);
            chk($sformatf("w8 op%0d P", n), 32'(p8), 32'(exp8));
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) step();
            out_ready8 = 1;
            step();
            out_ready8 = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
